// File: rtl/accel_pkg.sv
// Shared widths and FSM state codes for the accelerator job scheduler.
// Optional feature macro used by the top level: ACC_JOB_COUNT_EN.
package accel_pkg;

  localparam int UI_W   = 2;
  localparam int VI_W   = 5;
  localparam int DATA_W = 21;

  // Scheduler FSM state codes.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t BUSY  = 2'd2;
  localparam state_t RESP  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request bit found
// scanning upward from last_id+1, wrapping modulo N_REQ.
module rr_arbiter
  import accel_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

  // One spare bit so last_id + offset (at most 2*N_REQ-1) cannot overflow.
  logic [ID_W:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit is assigned last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = {1'b0, last_id} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) begin
        idx = idx - (ID_W+1)'(N_REQ);
      end
      if (req[idx[ID_W-1:0]]) begin
        winner = idx[ID_W-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accel_job_scheduler.sv
// Shares one accelerator engine between N_REQ requesters: round-robin
// arbitration, operand latching, engine start pulse, result capture and a
// valid/ready response port back to the owning requester.
// Optional macro ACC_JOB_COUNT_EN adds per-requester 8-bit completed-job counters.
module accel_job_scheduler
  import accel_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [UI_W*N_REQ-1:0]   ui_in,
  input  logic [VI_W*N_REQ-1:0]   vi_in,
  output logic [N_REQ-1:0]        grant,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  input  logic                    rsp_ready,
  output logic                    busy,
  output logic                    acc_wr_start,
  output logic [UI_W-1:0]         acc_ui,
  output logic [VI_W-1:0]         acc_vi,
  input  logic                    acc_done,
  input  logic                    acc_wr_req,
  input  logic [DATA_W-1:0]       acc_wr_data
`ifdef ACC_JOB_COUNT_EN
  ,
  output logic [8*N_REQ-1:0]      job_count
`endif
);

  state_t              state_reg;
  logic [ID_W-1:0]     cur_id_reg;
  logic [ID_W-1:0]     last_id_reg;
  logic [UI_W-1:0]     ui_reg;
  logic [VI_W-1:0]     vi_reg;
  logic [DATA_W-1:0]   capture_reg;

  logic [ID_W-1:0]     win_id;
  logic                win_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (req),
    .last_id (last_id_reg),
    .winner  (win_id),
    .valid   (win_valid)
  );

  // Outputs are decoded from the state so they can never outlive their state.
  assign busy         = (state_reg != IDLE);
  assign acc_wr_start = (state_reg == START);
  assign grant        = acc_wr_start ? (N_REQ'(1) << cur_id_reg) : '0;
  assign rsp_valid    = (state_reg == RESP);
  assign rsp_id       = rsp_valid ? cur_id_reg : '0;
  assign rsp_data     = rsp_valid ? capture_reg : '0;
  assign acc_ui       = ui_reg;
  assign acc_vi       = vi_reg;

  // Job FSM: arbitrate in IDLE, one-cycle start, capture writes until done,
  // then hold the response until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cur_id_reg  <= '0;
      last_id_reg <= ID_W'(N_REQ - 1);
      ui_reg      <= '0;
      vi_reg      <= '0;
      capture_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            cur_id_reg  <= win_id;
            ui_reg      <= ui_in[int'(win_id)*UI_W +: UI_W];
            vi_reg      <= vi_in[int'(win_id)*VI_W +: VI_W];
            capture_reg <= '0;
            state_reg   <= START;
          end
        end
        START: begin
          // Engine handshake inputs are deliberately ignored here.
          state_reg <= BUSY;
        end
        BUSY: begin
          if (acc_wr_req) begin
            capture_reg <= acc_wr_data;
          end
          if (acc_done) begin
            state_reg <= RESP;
          end
        end
        default: begin
          // RESP: no arbitration here, even on the accepting cycle.
          if (rsp_ready) begin
            last_id_reg <= cur_id_reg;
            state_reg   <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef ACC_JOB_COUNT_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_count
    logic [7:0] count_reg;

    // Count accepted responses owned by this requester; wraps 255 -> 0.
    always_ff @(posedge clk) begin
      if (rst) begin
        count_reg <= '0;
      end else if (rsp_valid && rsp_ready && (cur_id_reg == ID_W'(gi))) begin
        count_reg <= count_reg + 8'd1;
      end
    end

    assign job_count[8*gi +: 8] = count_reg;
  end
`endif

endmodule

// File: tb/tb_accel_job_scheduler.sv
// Self-checking bench for accel_job_scheduler (N_REQ=2): directed jobs,
// a scripted engine, and a job-level reference model compared every cycle.
module tb_accel_job_scheduler;

  localparam int N_REQ = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [3:0]  ui_in;
  logic [9:0]  vi_in;
  logic        rsp_ready;
  logic        acc_done;
  logic        acc_wr_req;
  logic [20:0] acc_wr_data;
  logic [1:0]  grant;
  logic        rsp_valid;
  logic        rsp_id;
  logic [20:0] rsp_data;
  logic        busy;
  logic        acc_wr_start;
  logic [1:0]  acc_ui;
  logic [4:0]  acc_vi;
`ifdef ACC_JOB_COUNT_EN
  logic [15:0] job_count;
`endif

  int total = 0;
  int bad   = 0;

  // Engine script knobs: 0 write+done, 1 two writes (second with done),
  // 2 done only, 3 never finishes.
  int          eng_mode  = 0;
  int          eng_gap   = 0;
  logic        eng_noise = 1'b0;
  logic [20:0] eng_d1    = '0;
  logic [20:0] eng_d2    = '0;

  accel_job_scheduler #(.N_REQ(N_REQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .ui_in        (ui_in),
    .vi_in        (vi_in),
    .grant        (grant),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .busy         (busy),
    .acc_wr_start (acc_wr_start),
    .acc_ui       (acc_ui),
    .acc_vi       (acc_vi),
    .acc_done     (acc_done),
    .acc_wr_req   (acc_wr_req),
    .acc_wr_data  (acc_wr_data)
`ifdef ACC_JOB_COUNT_EN
    ,
    .job_count    (job_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requesting index after 'last', wrapping.
  function automatic int rr_pick(input logic [1:0] r, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      int i;
      i = (last + k) % N_REQ;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  logic        p_rst = 1'b1;
  logic [1:0]  p_req = '0;
  logic [3:0]  p_ui  = '0;
  logic [9:0]  p_vi  = '0;
  bit          job_active, in_busy, rsp_exp, hs_prev, new_grant;
  int          owner = 0;
  int          model_last = N_REQ - 1;
  int          w;
  logic [1:0]  exp_ui = '0;
  logic [4:0]  exp_vi = '0;
  logic [20:0] exp_data = '0;
  int          cnt [N_REQ];

  // Outputs seen at a falling edge were produced by the inputs captured one edge earlier.
  always @(negedge clk) begin
    new_grant = 1'b0;
    if (p_rst) begin
      chk("m_rst_grant", grant, 0);
      chk("m_rst_start", acc_wr_start, 0);
      chk("m_rst_valid", rsp_valid, 0);
      chk("m_rst_id", rsp_id, 0);
      chk("m_rst_data", rsp_data, 0);
      chk("m_rst_busy", busy, 0);
      chk("m_rst_ui", acc_ui, 0);
      chk("m_rst_vi", acc_vi, 0);
      job_active = 0; in_busy = 0; rsp_exp = 0; hs_prev = 0;
      model_last = N_REQ - 1;
      for (int i = 0; i < N_REQ; i++) cnt[i] = 0;
    end else begin
      if (!job_active && p_req != 0) begin
        w = rr_pick(p_req, model_last);
        chk("m_grant", grant, 32'(1 << w));
        chk("m_start", acc_wr_start, 1);
        job_active = 1; owner = w; exp_data = '0; new_grant = 1'b1;
        exp_ui = p_ui[2*w +: 2];
        exp_vi = p_vi[5*w +: 5];
      end else begin
        chk("m_nogrant", grant, 0);
        chk("m_nostart", acc_wr_start, 0);
      end
      if (job_active && !hs_prev) begin
        chk("m_ui", acc_ui, exp_ui);
        chk("m_vi", acc_vi, exp_vi);
      end
      if (rsp_exp) begin
        chk("m_rsp_valid", rsp_valid, 1);
        chk("m_rsp_id", rsp_id, owner);
        chk("m_rsp_data", rsp_data, exp_data);
      end else begin
        chk("m_rsp_idle", rsp_valid, 0);
      end
      chk("m_busy", busy, (job_active && !hs_prev) ? 1 : 0);
      if (hs_prev) begin
        job_active = 0; hs_prev = 0; model_last = owner;
        cnt[owner] = cnt[owner] + 1;
      end
      if (rsp_exp && rsp_ready && !rst) begin
        rsp_exp = 0; hs_prev = 1;
      end
      if (in_busy && !rst) begin
        if (acc_wr_req) exp_data = acc_wr_data;
        if (acc_done) begin
          in_busy = 0; rsp_exp = 1;
        end
      end
      if (new_grant) in_busy = 1;
    end
`ifdef ACC_JOB_COUNT_EN
    for (int i = 0; i < N_REQ; i++) chk("m_job_count", job_count[8*i +: 8], cnt[i] % 256);
`endif
    p_rst = rst; p_req = req; p_ui = ui_in; p_vi = vi_in;
  end

  // ---------------- engine model ----------------
  // Reacts to the start pulse; optionally pokes done/write during START.
  initial begin
    acc_done = 1'b0; acc_wr_req = 1'b0; acc_wr_data = '0;
    forever begin
      @(negedge clk);
      if (acc_wr_start === 1'b1 && rst === 1'b0) begin
        #1;
        if (eng_noise) begin
          acc_done = 1'b1; acc_wr_req = 1'b1; acc_wr_data = 21'h1FFFF;
        end
        @(posedge clk); #1;
        acc_done = 1'b0; acc_wr_req = 1'b0; acc_wr_data = '0;
        repeat (eng_gap) begin @(posedge clk); #1; end
        case (eng_mode)
          0: begin
            acc_wr_req = 1'b1; acc_wr_data = eng_d1;
            @(posedge clk); #1;
            acc_wr_req = 1'b0; acc_done = 1'b1;
            @(posedge clk); #1;
            acc_done = 1'b0;
          end
          1: begin
            acc_wr_req = 1'b1; acc_wr_data = eng_d1;
            @(posedge clk); #1;
            acc_wr_req = 1'b0;
            @(posedge clk); #1;
            acc_wr_req = 1'b1; acc_wr_data = eng_d2; acc_done = 1'b1;
            @(posedge clk); #1;
            acc_wr_req = 1'b0; acc_done = 1'b0;
          end
          2: begin
            acc_done = 1'b1;
            @(posedge clk); #1;
            acc_done = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(output logic [1:0] g, output int n);
    g = '0; n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (grant != 0) begin
        g = grant; n = i;
        return;
      end
    end
    chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [1:0] g;
    int n;
    logic [1:0] rr_exp [4];
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    rst = 1'b1; req = '0; ui_in = '0; vi_in = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_valid", rsp_valid, 0);
    step(); rst = 1'b0;
    step();

    // Single job for requester 0.
    eng_mode = 0; eng_gap = 2; eng_d1 = 21'h0ABCD;
    ui_in[1:0] = 2'd2; vi_in[4:0] = 5'd13; req = 2'b01;
    wait_grant(g, n);
    chk("t1_grant", g, 2'b01);
    chk("t1_start", acc_wr_start, 1);
    chk("t1_latency", n, 2);
    step(); req = '0;
    wait_rsp();
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_data", rsp_data, 21'h0ABCD);
    chk("t1_ui_held", acc_ui, 2);
    chk("t1_vi_held", acc_vi, 13);
    wait_idle();

    // Reset while the engine is busy.
    eng_mode = 3; ui_in[1:0] = 2'd1; vi_in[4:0] = 5'd5;
    step(); req = 2'b01;
    wait_grant(g, n);
    step(); req = '0;
    step(); step();
    chk("rm_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rm_grant", grant, 0);
    chk("rm_valid", rsp_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_start", acc_wr_start, 0);
    chk("rm_ui", acc_ui, 0);
    chk("rm_vi", acc_vi, 0);
    rst = 1'b0;

    // Round-robin with both requesters held high.
    eng_mode = 0; eng_gap = 0; eng_d1 = 21'h00777;
    ui_in = {2'd3, 2'd1}; vi_in = {5'd22, 5'd5}; req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_grant(g, n);
      chk("rr_grant", g, rr_exp[j]);
    end
    step(); req = '0;
    wait_idle();

    // Backpressure with requester 1 pending.
    rsp_ready = 1'b0; eng_d1 = 21'h12345;
    step(); req = 2'b01;
    wait_grant(g, n);
    step(); req = 2'b10;
    wait_rsp();
    for (int j = 0; j < 5; j++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 21'h12345);
      chk("bp_grant", grant, 0);
      chk("bp_start", acc_wr_start, 0);
      @(negedge clk);
    end
    eng_d1 = 21'h54321;
    step(); rsp_ready = 1'b1;
    wait_grant(g, n);
    chk("bp_grant_after", g, 2'b10);
    step(); req = '0;
    wait_rsp();
    chk("bp_rsp_id", rsp_id, 1);
    chk("bp_rsp_data", rsp_data, 21'h54321);
    wait_idle();

    // Two writes, the second coincident with done.
    eng_mode = 1; eng_d1 = 21'h00001; eng_d2 = 21'h00002;
    step(); req = 2'b01;
    wait_grant(g, n);
    step(); req = '0;
    wait_rsp();
    chk("mw_data", rsp_data, 21'h00002);
    wait_idle();

    // Done with no write; engine noise during START must be ignored.
    eng_mode = 2; eng_noise = 1'b1;
    step(); req = 2'b10;
    wait_grant(g, n);
    chk("nw_grant", g, 2'b10);
    step(); req = '0;
    wait_rsp();
    chk("nw_data", rsp_data, 0);
    chk("nw_id", rsp_id, 1);
    wait_idle();
    eng_noise = 1'b0;

`ifdef ACC_JOB_COUNT_EN
    // Counter: 3 jobs for requester 1, then wrap after 256.
    rst = 1'b1; step(); step(); rst = 1'b0;
    eng_mode = 2;
    for (int j = 0; j < 256; j++) begin
      step(); req = 2'b10;
      wait_grant(g, n);
      step(); req = '0;
      wait_idle();
      if (j == 2) begin
        chk("jc_hi3", job_count[15:8], 3);
        chk("jc_lo0", job_count[7:0], 0);
      end
    end
    chk("jc_wrap", job_count[15:8], 0);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_job_scheduler.md
Name: accel_job_scheduler

Overview:
- Shares one Accelerator engine between N_REQ requesters, each submitting jobs of the form (ui, vi).
- Round-robin arbitration selects a requester. The block latches that requester's operands, pulses the engine start and holds the operands stable until the engine finishes.
- It captures the engine's write data and returns the result to the owning requester through a valid/ready response port.
- Sits between the requester front-ends and the Accelerator's wrStart/ui/vi/done/wrReq/wrData interface.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(N_REQ) (minimum 1), requester index width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester job request; held with its operands until grant.
- ui_in  in  2*N_REQ  per-requester ui operand; requester i uses slice [2i+1:2i].
- vi_in  in  5*N_REQ  per-requester vi operand; requester i uses slice [5i+4:5i].
- grant  out  N_REQ  one-hot, one-cycle pulse meaning the job is accepted.
- rsp_valid  out  1  result available.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  21  result word.
- rsp_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.
- acc_wr_start  out  1  engine start pulse.
- acc_ui  out  2  ui operand to the engine.
- acc_vi  out  5  vi operand to the engine.
- acc_done  in  1  engine job complete.
- acc_wr_req  in  1  engine write-data valid.
- acc_wr_data  in  21  engine result.

Behaviour:
- Reset values:
  - grant=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - acc_wr_start=0, acc_ui=0, acc_vi=0.
  - state=IDLE, last_id=N_REQ-1, so requester 0 has first priority after reset.
- FSM states are IDLE, START, BUSY and RESP.
- IDLE, when req!=0:
  - Winner = first set req bit scanning from last_id+1 upward, wrapping modulo N_REQ.
  - Register cur_id=winner, acc_ui and acc_vi from the winner's slices.
  - Clear the capture register to 0, then go to START.
  - When req=0, stay in IDLE.
- START (exactly one cycle):
  - acc_wr_start=1 and grant[cur_id]=1.
  - Next state is BUSY.
  - acc_done and acc_wr_req are ignored in this state.
- BUSY:
  - acc_ui and acc_vi are held constant.
  - Each cycle with acc_wr_req=1 loads acc_wr_data into the capture register; the last write wins.
  - On acc_done=1, go to RESP. If acc_wr_req is also high in that cycle, its data is captured.
  - A job that completes with no acc_wr_req returns rsp_data=0.
- RESP:
  - rsp_valid=1, rsp_id=cur_id, rsp_data=capture.
  - When rsp_ready=1: last_id=cur_id, rsp_valid is 0 on the next cycle, go to IDLE.
  - New requests are not arbitrated while in RESP, including in the cycle rsp_ready is accepted; arbitration resumes in IDLE.
- Latency:
  - req sampled in IDLE at cycle T gives acc_wr_start and grant at T+1.
  - acc_done at cycle D gives rsp_valid at D+1.
  - Minimum turnaround between consecutive jobs is 4 cycles plus engine time.
- Requester rules:
  - A requester may drop req only after seeing grant. Dropping it earlier withdraws the request with no side effects.
  - A requester that keeps req high after grant is treated as a new request.
- Fairness: a continuously requesting requester waits for at most N_REQ-1 other jobs.
- rst asserted in any state: everything returns to reset values on the next edge. Any in-flight engine job and any pending response are discarded; the engine is reset by the same rst.

Optional Feature:
- Macro: ACC_JOB_COUNT_EN.
- When defined:
  - Adds output job_count [8*N_REQ], one 8-bit counter per requester.
  - A counter increments on the rsp_valid&rsp_ready handshake for that requester and wraps 255 to 0.
  - All counters reset to 0.
- When undefined: the port and counters are absent and all other behaviour is identical.

Decomposition:
- Package accel_pkg:
  - UI_W=2, VI_W=5, DATA_W=21.
  - State enum: IDLE, START, BUSY, RESP.
- One sub-module, rr_arbiter (N_REQ). Combinational: takes req and last_id, returns winner index and a valid flag.

Test Plan:
- Single job: req=01, ui_in[1:0]=2, vi_in[4:0]=13; engine model asserts acc_wr_req with data 0x0ABCD, then acc_done. Required: grant=01 and acc_wr_start one cycle after req; acc_ui=2 and acc_vi=13 held through BUSY; rsp_valid with rsp_id=0, rsp_data=0x0ABCD one cycle after acc_done.
- Round-robin: req=11 held continuously with immediate rsp_ready. Required: grants alternate 01,10,01,10 across 4 jobs, first grant to requester 0.
- Backpressure: rsp_ready=0 for 5 cycles while req=10 is pending. Required: rsp_valid and rsp_data stable for all 5 cycles, no acc_wr_start, grant=10 only after acceptance.
- Multiple and coincident writes: acc_wr_req with 0x00001, then 0x00002 in the same cycle as acc_done. Required: rsp_data=0x00002. Done with no write: rsp_data=0.
- Reset mid-job: assert rst during BUSY. Required: next cycle all outputs are 0, busy=0, and the next req=11 grants requester 0.
- With ACC_JOB_COUNT_EN: 3 jobs for requester 1. Required: job_count[15:8]=3 and job_count[7:0]=0; after 256 jobs the counter wraps to 0.
